// File: rtl/reg_ctrl.sv
// Command sequencer for a downstream 4-bit register: 2-entry command FIFO plus IDLE/EXEC FSM with registered one-hot controls.
// Define REG_CTRL_ROTATE_EN to execute ROT as a rotate-right; otherwise ROT behaves as a NOP.
module reg_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [3:0] cmd_cnt,
  input  logic [3:0] cmd_data,
  input  logic       cmd_sin,
  input  logic [3:0] reg_q,
  output logic       cl,
  output logic       ld,
  output logic       inc,
  output logic       dec,
  output logic       sr,
  output logic       sl,
  output logic [3:0] in,
  output logic       ir,
  output logic       il,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_CLR = 3'b001;
  localparam logic [2:0] OP_LD  = 3'b010;
  localparam logic [2:0] OP_INC = 3'b011;
  localparam logic [2:0] OP_DEC = 3'b100;
  localparam logic [2:0] OP_SR  = 3'b101;
  localparam logic [2:0] OP_SL  = 3'b110;
  localparam logic [2:0] OP_ROT = 3'b111;

  typedef enum logic {IDLE, EXEC} state_t;

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] cnt;
    logic [3:0] data;
    logic       sin;
  } cmd_t;

  state_t     state_q, state_d;
  cmd_t       fifo_q [2];
  cmd_t       fifo_d [2];
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [1:0] count_q, count_d;
  logic [3:0] rep_q, rep_d;
  logic       cl_q, cl_d, ld_q, ld_d, inc_q, inc_d, dec_q, dec_d;
  logic       sr_q, sr_d, sl_q, sl_d, rot_q, rot_d, sin_q, sin_d;
  logic [3:0] in_q, in_d;
  logic       done_q, done_d;

  logic       push;
  logic       pop;
  logic       last_cycle;
  cmd_t       head;

  assign cmd_ready  = (count_q < 2'd2);
  assign push       = cmd_valid && cmd_ready;
  assign head       = fifo_q[rd_ptr_q];
  assign last_cycle = (state_q == EXEC) && (rep_q == 4'd0);
  // A new command is taken either from IDLE or on the final cycle of the current one (zero bubble).
  assign pop        = (count_q != 2'd0) && ((state_q == IDLE) || last_cycle);

  always_comb begin
    state_d  = state_q;
    fifo_d   = fifo_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    rep_d    = rep_q;
    cl_d     = cl_q;
    ld_d     = ld_q;
    inc_d    = inc_q;
    dec_d    = dec_q;
    sr_d     = sr_q;
    sl_d     = sl_q;
    rot_d    = rot_q;
    sin_d    = sin_q;
    in_d     = in_q;
    done_d   = 1'b0;

    if (push) begin
      fifo_d[wr_ptr_q] = {cmd_op, cmd_cnt, cmd_data, cmd_sin};
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    if (state_q == EXEC) begin
      if (rep_q != 4'd0) begin
        rep_d = rep_q - 4'd1;
      end else begin
        done_d  = 1'b1;
        state_d = IDLE;
        cl_d    = 1'b0;
        ld_d    = 1'b0;
        inc_d   = 1'b0;
        dec_d   = 1'b0;
        sr_d    = 1'b0;
        sl_d    = 1'b0;
        rot_d   = 1'b0;
        in_d    = 4'h0;
      end
    end

    // Fields are captured here so later pushes cannot disturb the executing command.
    if (pop) begin
      state_d = EXEC;
      cl_d    = 1'b0;
      ld_d    = 1'b0;
      inc_d   = 1'b0;
      dec_d   = 1'b0;
      sr_d    = 1'b0;
      sl_d    = 1'b0;
      rot_d   = 1'b0;
      in_d    = 4'h0;
      rep_d   = 4'd0;
      sin_d   = head.sin;
      case (head.op)
        OP_NOP: ;
        OP_CLR: cl_d = 1'b1;
        OP_LD: begin
          ld_d = 1'b1;
          in_d = head.data;
        end
        OP_INC: begin
          inc_d = 1'b1;
          rep_d = head.cnt;
        end
        OP_DEC: begin
          dec_d = 1'b1;
          rep_d = head.cnt;
        end
        OP_SR: begin
          sr_d  = 1'b1;
          rep_d = head.cnt;
        end
        OP_SL: begin
          sl_d  = 1'b1;
          rep_d = head.cnt;
        end
        OP_ROT: begin
`ifdef REG_CTRL_ROTATE_EN
          sr_d  = 1'b1;
          rot_d = 1'b1;
          rep_d = head.cnt;
`endif
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      for (int i = 0; i < 2; i++) begin
        fifo_q[i] <= '0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      rep_q    <= 4'd0;
      cl_q     <= 1'b0;
      ld_q     <= 1'b0;
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      sr_q     <= 1'b0;
      sl_q     <= 1'b0;
      rot_q    <= 1'b0;
      sin_q    <= 1'b0;
      in_q     <= 4'h0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      fifo_q   <= fifo_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      rep_q    <= rep_d;
      cl_q     <= cl_d;
      ld_q     <= ld_d;
      inc_q    <= inc_d;
      dec_q    <= dec_d;
      sr_q     <= sr_d;
      sl_q     <= sl_d;
      rot_q    <= rot_d;
      sin_q    <= sin_d;
      in_q     <= in_d;
      done_q   <= done_d;
    end
  end

  assign cl   = cl_q;
  assign ld   = ld_q;
  assign inc  = inc_q;
  assign dec  = dec_q;
  assign sr   = sr_q;
  assign sl   = sl_q;
  assign in   = in_q;
  // Rotate feeds the register's own LSB back in, so ir must follow reg_q combinationally.
  assign ir   = rot_q ? reg_q[0] : (sr_q & sin_q);
  assign il   = sl_q & sin_q;
  assign busy = (state_q == EXEC) || (count_q != 2'd0);
  assign done = done_q;

endmodule

// File: tb/tb_reg_ctrl.sv
// Directed bench for reg_ctrl with a behavioural model of the attached 4-bit register.
module tb_reg_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_cnt;
  logic [3:0] cmd_data;
  logic       cmd_sin;
  logic [3:0] rmod = 4'h0;
  logic       cl, ld, inc, dec, sr, sl;
  logic [3:0] in_w;
  logic       ir, il, busy, done;
  logic [5:0] ctl_w;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  reg_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .cmd_data(cmd_data), .cmd_sin(cmd_sin),
    .reg_q(rmod), .cl(cl), .ld(ld), .inc(inc), .dec(dec), .sr(sr), .sl(sl),
    .in(in_w), .ir(ir), .il(il), .busy(busy), .done(done)
  );

  assign ctl_w = {cl, ld, inc, dec, sr, sl};

  // Downstream register driven by the controller outputs.
  always @(posedge clk) begin
    if (cl)       rmod <= 4'h0;
    else if (ld)  rmod <= in_w;
    else if (inc) rmod <= rmod + 4'd1;
    else if (dec) rmod <= rmod - 4'd1;
    else if (sr)  rmod <= {ir, rmod[3:1]};
    else if (sl)  rmod <= {rmod[2:0], il};
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0] op;
    logic [3:0] cnt;
    logic [3:0] data;
    logic       sin;
    logic [5:0] ctl;
    logic [3:0] in_v;
    logic       ir_v;
    logic       il_v;
    int         len;
    logic [3:0] reg_v;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  logic [5:0] ctl_log  [20];
  logic       done_log [20];
  logic       busy_log [20];
  logic [3:0] reg_log  [20];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int n_sr;
    bit accept;

    //            op    cnt    data   sin   ctl        in     ir    il   len reg
    vecs[0]  = '{3'd2, 4'd0,  4'hA, 1'b0, 6'b010000, 4'hA, 1'b0, 1'b0, 1,  4'hA};
    vecs[1]  = '{3'd3, 4'd3,  4'h0, 1'b0, 6'b001000, 4'h0, 1'b0, 1'b0, 4,  4'hE};
    vecs[2]  = '{3'd4, 4'd1,  4'h0, 1'b0, 6'b000100, 4'h0, 1'b0, 1'b0, 2,  4'hC};
    vecs[3]  = '{3'd1, 4'd5,  4'h0, 1'b0, 6'b100000, 4'h0, 1'b0, 1'b0, 1,  4'h0};
    vecs[4]  = '{3'd0, 4'd7,  4'hF, 1'b1, 6'b000000, 4'h0, 1'b0, 1'b0, 1,  4'h0};
    vecs[5]  = '{3'd2, 4'd9,  4'h5, 1'b0, 6'b010000, 4'h5, 1'b0, 1'b0, 1,  4'h5};
    vecs[6]  = '{3'd5, 4'd0,  4'h0, 1'b1, 6'b000010, 4'h0, 1'b1, 1'b0, 1,  4'hA};
    vecs[7]  = '{3'd6, 4'd1,  4'h0, 1'b0, 6'b000001, 4'h0, 1'b0, 1'b0, 2,  4'h8};
    vecs[8]  = '{3'd6, 4'd0,  4'h0, 1'b1, 6'b000001, 4'h0, 1'b0, 1'b1, 1,  4'h1};
`ifdef REG_CTRL_ROTATE_EN
    vecs[9]  = '{3'd7, 4'd0,  4'h0, 1'b0, 6'b000010, 4'h0, 1'b1, 1'b0, 1,  4'h8};
`else
    vecs[9]  = '{3'd7, 4'd0,  4'h0, 1'b0, 6'b000000, 4'h0, 1'b0, 1'b0, 1,  4'h1};
`endif
    vecs[10] = '{3'd2, 4'd0,  4'h7, 1'b0, 6'b010000, 4'h7, 1'b0, 1'b0, 1,  4'h7};
    vecs[11] = '{3'd4, 4'd15, 4'h0, 1'b0, 6'b000100, 4'h0, 1'b0, 1'b0, 16, 4'h7};
    vecs[12] = '{3'd3, 4'd0,  4'h0, 1'b0, 6'b001000, 4'h0, 1'b0, 1'b0, 1,  4'h8};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_cnt = 4'd0; cmd_data = 4'd0; cmd_sin = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_outputs", {2'b0, ctl_w, in_w, ir, il, busy, done}, 16'h0);
    check("reset_ready", cmd_ready, 1'b1);

    // Single commands issued from IDLE
    for (int v = 0; v < NVEC; v++) begin
      check($sformatf("v%0d_ready", v), cmd_ready, 1'b1);
      cmd_op = vecs[v].op; cmd_cnt = vecs[v].cnt; cmd_data = vecs[v].data; cmd_sin = vecs[v].sin;
      cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      check($sformatf("v%0d_prepop", v), {busy, ctl_w}, {1'b1, 6'b0});
      for (int c = 0; c < vecs[v].len; c++) begin
        @(negedge clk);
        check($sformatf("v%0d_cyc%0d {ctl,in,ir,il,done}", v, c), {3'b0, ctl_w, in_w, ir, il, done},
              {3'b0, vecs[v].ctl, vecs[v].in_v, vecs[v].ir_v, vecs[v].il_v, 1'b0});
      end
      @(negedge clk);
      check($sformatf("v%0d_done {done,ctl,busy}", v), {done, ctl_w, busy}, {1'b1, 6'b0, 1'b0});
      check($sformatf("v%0d_reg", v), rmod, vecs[v].reg_v);
      @(negedge clk);
      check($sformatf("v%0d_done_clear", v), done, 1'b0);
    end

    // Back-to-back LD/SL/CLR queued behind a running DEC so the FIFO fills
    cmd_op = 3'd4; cmd_cnt = 4'd3; cmd_data = 4'h0; cmd_sin = 1'b0; cmd_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    cmd_op = 3'd2; cmd_cnt = 4'd0; cmd_data = 4'h1;
    @(posedge clk); @(negedge clk);
    cmd_op = 3'd6; cmd_cnt = 4'd1; cmd_data = 4'h0; cmd_sin = 1'b1;
    @(posedge clk); @(negedge clk);
    check("b2b_ready_full", cmd_ready, 1'b0);
    cmd_op = 3'd1; cmd_cnt = 4'd2; cmd_sin = 1'b0;
    for (int k = 0; k < 20; k++) begin
      ctl_log[k] = ctl_w; done_log[k] = done; busy_log[k] = busy; reg_log[k] = rmod;
      accept = cmd_valid && cmd_ready;
      @(posedge clk); @(negedge clk);
      if (accept) cmd_valid = 1'b0;
    end
    check("b2b_clr_accepted", cmd_valid, 1'b0);
    cmd_valid = 1'b0;
    idx = -1;
    for (int k = 19; k >= 0; k--) if (ctl_log[k] == 6'b010000) idx = k;
    if (idx < 1 || idx > 15) begin
      n_checks++; n_fail++;
      $display("FAIL b2b_ld_found: ld cycle index %0d, expected within 1..15", idx);
    end else begin
      check("b2b_ctl_before_ld", ctl_log[idx-1], 6'b000100);
      check("b2b_ctl_ld",   ctl_log[idx],   6'b010000);
      check("b2b_ctl_sl0",  ctl_log[idx+1], 6'b000001);
      check("b2b_ctl_sl1",  ctl_log[idx+2], 6'b000001);
      check("b2b_ctl_cl",   ctl_log[idx+3], 6'b100000);
      check("b2b_ctl_end",  ctl_log[idx+4], 6'b000000);
      check("b2b_done_pattern", {done_log[idx], done_log[idx+1], done_log[idx+2], done_log[idx+3], done_log[idx+4]}, 5'b11011);
      check("b2b_reg_after_ld",  reg_log[idx+1], 4'h1);
      check("b2b_reg_after_sl0", reg_log[idx+2], 4'h3);
      check("b2b_reg_after_sl1", reg_log[idx+3], 4'h7);
      check("b2b_reg_after_cl",  reg_log[idx+4], 4'h0);
      check("b2b_busy_end", busy_log[idx+4], 1'b0);
    end

    // SR cnt=15 aborted by reset during its 8th cycle
    cmd_op = 3'd5; cmd_cnt = 4'd15; cmd_data = 4'h0; cmd_sin = 1'b0; cmd_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    n_sr = 0;
    for (int k = 0; k < 40; k++) begin
      if (sr) n_sr++;
      if (n_sr == 8) break;
      @(negedge clk);
    end
    check("abort_sr_cycles_seen", n_sr, 8);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_outputs", {2'b0, ctl_w, in_w, ir, il, busy, done}, 16'h0);
    check("abort_ready", cmd_ready, 1'b1);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("abort_quiet%0d {done,ctl,busy}", k), {done, ctl_w, busy}, 8'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
